// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one change-detect ram between P0 (instruction fetch) and P1 (data load/store).
// Registered ram drive, one outstanding transaction, one-cycle ack with read data or timeout error.
module ram_arbiter #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int PRIO    = 0,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_wr,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic          p0_err,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_wr,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic          p1_err,
    output logic [DW-1:0] p1_rdata,
    output logic [DW-1:0] mem_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr,
    input  logic          mem_response,
    input  logic [DW-1:0] mem_out,
    output logic          busy
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETTLE, WAIT} state_t;

    state_t           state_q, state_d;
    logic             grant_q, grant_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    mem_data_q, mem_data_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic             mem_wr_q, mem_wr_d;
    logic [1:0]       ack_q, ack_d, err_q, err_d;
    logic [1:0][DW-1:0] rdata_q, rdata_d;
    logic [1:0]       elig;
    logic             pick;

    // a port still holding req during its own ack cycle is not a new request
    assign elig = {p1_req, p0_req} & ~ack_q;
    assign pick = &elig ? ((PRIO == 1) ? 1'b0 : ~grant_q) : elig[1];

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        mem_data_d = mem_data_q;
        mem_addr_d = mem_addr_q;
        mem_wr_d   = mem_wr_q;
        ack_d      = '0;
        err_d      = '0;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: if (|elig) begin
                grant_d    = pick;
                cnt_d      = '0;
                mem_wr_d   = pick ? p1_wr : p0_wr;
                mem_addr_d = pick ? p1_addr : p0_addr;
                mem_data_d = pick ? p1_wdata : p0_wdata;
                state_d    = SETTLE;
            end
            SETTLE: state_d = WAIT;
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (mem_response) begin
                    ack_d[grant_q] = 1'b1;
                    rdata_d[grant_q] = mem_wr_q ? rdata_q[grant_q] : mem_out;
                    state_d = IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    ack_d[grant_q] = 1'b1;
                    err_d[grant_q] = 1'b1;
                    rdata_d[grant_q] = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= 1'b1;
            cnt_q      <= '0;
            mem_data_q <= '0;
            mem_addr_q <= '0;
            mem_wr_q   <= 1'b0;
            ack_q      <= '0;
            err_q      <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            mem_data_q <= mem_data_d;
            mem_addr_q <= mem_addr_d;
            mem_wr_q   <= mem_wr_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    assign mem_data = mem_data_q;
    assign mem_addr = mem_addr_q;
    assign mem_wr   = mem_wr_q;
    assign p0_ack   = ack_q[0];
    assign p1_ack   = ack_q[1];
    assign p0_err   = err_q[0];
    assign p1_err   = err_q[1];
    assign p0_rdata = rdata_q[0];
    assign p1_rdata = rdata_q[1];
    assign busy     = state_q != IDLE;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vector table, corner sequences and random traffic against a transaction-level model.
module tb_ram_arbiter;
    localparam int TO = 15;

    logic        clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic        p0_req = 1'b0, p0_wr = 1'b0, p1_req = 1'b0, p1_wr = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic [31:0] p0_rdata, p1_rdata, mem_data, mem_addr, mem_out;
    logic        mem_wr, mem_response, busy;
    logic        no_resp = 1'b0;

    ram_arbiter #(.DW(32), .AW(32), .PRIO(0), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_data(mem_data), .mem_addr(mem_addr), .mem_wr(mem_wr),
        .mem_response(mem_response), .mem_out(mem_out), .busy(busy)
    );

    // fixed-priority instance against an always-ready ram, used only for tie-break checks
    logic        f_req0 = 1'b0, f_req1 = 1'b0;
    logic        f_ack0, f_err0, f_ack1, f_err1, f_mem_wr, f_busy;
    logic [31:0] f_rdata0, f_rdata1, f_mem_data, f_mem_addr;

    ram_arbiter #(.DW(32), .AW(32), .PRIO(1), .TIMEOUT(TO)) u_fix (
        .clk(clk), .rst(rst),
        .p0_req(f_req0), .p0_wr(1'b0), .p0_addr(32'h0), .p0_wdata(32'h0),
        .p0_ack(f_ack0), .p0_err(f_err0), .p0_rdata(f_rdata0),
        .p1_req(f_req1), .p1_wr(1'b0), .p1_addr(32'h0), .p1_wdata(32'h0),
        .p1_ack(f_ack1), .p1_err(f_err1), .p1_rdata(f_rdata1),
        .mem_data(f_mem_data), .mem_addr(f_mem_addr), .mem_wr(f_mem_wr),
        .mem_response(1'b1), .mem_out(32'hA5), .busy(f_busy)
    );

    // change-detect ram: response drops for one cycle whenever its inputs change
    logic [31:0] ram [16] = '{default: '0};
    logic [64:0] ram_prev = '1;
    logic        ram_resp = 1'b0;
    logic [31:0] ram_out = '0;
    always @(posedge clk) begin
        ram_resp <= ({mem_wr, mem_addr, mem_data} == ram_prev);
        ram_prev <= {mem_wr, mem_addr, mem_data};
        if (mem_wr) ram[mem_addr[3:0]] <= mem_data;
        else ram_out <= ram[mem_addr[3:0]];
    end
    assign mem_response = ram_resp & ~no_resp;
    assign mem_out = ram_out;

    // transaction-level reference
    logic [31:0] ref_mem [16] = '{default: '0};
    logic [31:0] ref_rd [2];
    logic [64:0] last_iss;
    int          last_g;
    int          n_tests = 0, n_fail = 0;

    typedef struct {
        int          port;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
        int          lat;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        last_iss  = '0;
        last_g    = 1;
        ref_rd[0] = '0;
        ref_rd[1] = '0;
    endtask

    task automatic model(input int p, input bit w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] er, output int el);
        el = ({w, a, d} == last_iss) ? 2 : 3;
        last_iss = {w, a, d};
        last_g = p;
        if (w) ref_mem[a[3:0]] = d;
        else ref_rd[p] = ref_mem[a[3:0]];
        er = ref_rd[p];
    endtask

    task automatic run(input int p, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input bit ee, input int el, input string nm);
        bit seen = 0;
        int lat = -1;
        logic [31:0] rd = '0;
        logic e = 1'b0;
        @(negedge clk);
        if (p == 0) begin p0_wr = w; p0_addr = a; p0_wdata = d; p0_req = 1'b1; end
        else begin p1_wr = w; p1_addr = a; p1_wdata = d; p1_req = 1'b1; end
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk); #1;
            if (k == 0) chk({nm, "_memwr"}, 32'(mem_wr), 32'(w));
            if ((p == 0) ? p0_ack : p1_ack) begin
                seen = 1;
                lat = k;
                rd = (p == 0) ? p0_rdata : p1_rdata;
                e = (p == 0) ? p0_err : p1_err;
                chk({nm, "_other_ack"}, 32'((p == 0) ? p1_ack : p0_ack), 32'(0));
                chk({nm, "_busy"}, 32'(busy), 32'(0));
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        chk({nm, "_acked"}, 32'(seen), 32'(1));
        chk({nm, "_lat"}, 32'(lat), 32'(el));
        chk({nm, "_rdata"}, rd, er);
        chk({nm, "_err"}, 32'(e), 32'(ee));
        @(negedge clk);
    endtask

    task automatic both(input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                        input bit w1, input logic [31:0] a1, input logic [31:0] d1, input int n);
        int ew = (last_g == 0) ? 1 : 0;
        int got = 0, p, el;
        logic [31:0] er;
        @(negedge clk);
        p0_wr = w0; p0_addr = a0; p0_wdata = d0; p0_req = 1'b1;
        p1_wr = w1; p1_addr = a1; p1_wdata = d1; p1_req = 1'b1;
        for (int k = 0; k < 20 * n && got < n; k++) begin
            @(posedge clk); #1;
            if (p0_ack || p1_ack) begin
                p = p1_ack ? 1 : 0;
                chk("both_excl", 32'(p0_ack & p1_ack), 32'(0));
                chk("both_order", 32'(p), 32'(ew ^ (got % 2)));
                if (p == 0) model(0, w0, a0, d0, er, el);
                else model(1, w1, a1, d1, er, el);
                chk("both_rdata", (p == 0) ? p0_rdata : p1_rdata, er);
                chk("both_err", 32'((p == 0) ? p0_err : p1_err), 32'(0));
                got++;
                if (n == 2 && p == 0) p0_req = 1'b0;
                if (n == 2 && p == 1) p1_req = 1'b0;
                if (got == n) begin p0_req = 1'b0; p1_req = 1'b0; end
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        chk("both_done", 32'(got), 32'(n));
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] er, a, d;
        int el, p, fp;
        bit w, seen, any_ack;
        tbl[0] = '{1, 1'b1, 32'd5, 32'hDEAD, 32'h0,    1'b0, 3};
        tbl[1] = '{0, 1'b0, 32'd5, 32'h0,    32'hDEAD, 1'b0, 3};
        tbl[2] = '{0, 1'b0, 32'd5, 32'h0,    32'hDEAD, 1'b0, 2};
        tbl[3] = '{1, 1'b1, 32'd7, 32'h1234, 32'h0,    1'b0, 3};
        tbl[4] = '{0, 1'b0, 32'd7, 32'h0,    32'h1234, 1'b0, 3};
        tbl[5] = '{1, 1'b0, 32'd7, 32'h1,    32'h1234, 1'b0, 3};
        tbl[6] = '{1, 1'b0, 32'd7, 32'h1,    32'h1234, 1'b0, 2};
        tbl[7] = '{0, 1'b1, 32'd7, 32'h0,    32'h1234, 1'b0, 3};
        tbl[8] = '{0, 1'b0, 32'd7, 32'h0,    32'h0,    1'b0, 3};
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_mem_wr", 32'(mem_wr), 32'(0));
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_data", mem_data, 32'h0);
        chk("rst_acks", 32'({p0_ack, p1_ack, p0_err, p1_err}), 32'(0));
        chk("rst_rdata", p0_rdata | p1_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        // fixed priority: after a P0 grant, P0 still wins a tie
        f_req0 = 1'b1;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clk); #1;
            if (f_ack0) seen = 1;
        end
        f_req0 = 1'b0;
        chk("fix_solo_ack", 32'(seen), 32'(1));
        chk("fix_solo_rdata", f_rdata0, 32'hA5);
        repeat (2) @(negedge clk);
        f_req0 = 1'b1;
        f_req1 = 1'b1;
        seen = 0;
        fp = -1;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clk); #1;
            if (f_ack0 || f_ack1) begin seen = 1; fp = f_ack1 ? 1 : 0; end
        end
        f_req0 = 1'b0;
        f_req1 = 1'b0;
        chk("fix_prio", 32'(fp), 32'(0));
        for (int i = 0; i < 9; i++) begin
            model(tbl[i].port, tbl[i].wr, tbl[i].addr, tbl[i].wdata, er, el);
            run(tbl[i].port, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].err, tbl[i].lat, "vec");
        end
        both(1'b0, 32'd1, 32'h0, 1'b0, 32'd2, 32'h0, 2);
        both(1'b0, 32'd5, 32'h0, 1'b0, 32'd7, 32'h3, 6);
        no_resp = 1'b1;
        model(0, 1'b0, 32'd3, 32'd5, er, el);
        ref_rd[0] = '0;
        run(0, 1'b0, 32'd3, 32'd5, 32'h0, 1'b1, TO + 1, "timeout");
        no_resp = 1'b0;
        run(0, 1'b0, 32'd3, 32'd5, 32'h0, 1'b0, 2, "after_to");
        // reset while waiting on the ram: the write already reached the ram, no ack follows
        @(negedge clk);
        p1_wr = 1'b1; p1_addr = 32'd9; p1_wdata = 32'h77; p1_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_busy_before", 32'(busy), 32'(1));
        @(negedge clk);
        rst = 1'b1;
        p1_req = 1'b0;
        @(posedge clk); #1;
        chk("t6_busy", 32'(busy), 32'(0));
        chk("t6_mem_wr", 32'(mem_wr), 32'(0));
        chk("t6_mem_addr", mem_addr, 32'h0);
        chk("t6_ack", 32'(p1_ack), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        model(1, 1'b1, 32'd9, 32'h77, er, el);
        model_reset();
        any_ack = 0;
        repeat (4) begin
            @(posedge clk); #1;
            any_ack |= p0_ack | p1_ack;
        end
        chk("t6_no_ack", 32'(any_ack), 32'(0));
        run(0, 1'b0, 32'd9, 32'h0, 32'h77, 1'b0, 3, "t6_post");
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                both(1'($urandom_range(0, 1)), 32'($urandom_range(0, 3)), 32'($urandom_range(0, 2)) * 32'h1111,
                     1'($urandom_range(0, 1)), 32'($urandom_range(0, 3)), 32'($urandom_range(0, 2)) * 32'h1111, 2);
            end else begin
                p = $urandom_range(0, 1);
                w = 1'($urandom_range(0, 1));
                a = 32'($urandom_range(0, 3));
                d = 32'($urandom_range(0, 2)) * 32'h1111;
                model(p, w, a, d, er, el);
                run(p, w, a, d, er, 1'b0, el, "rand");
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
